// File: rtl/bvlshr_ne_witness_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : bvlshr_ne_witness_checker_if
// Description : Request/response bundle for the bvlshr not-equal witness
//               checker. The request side carries s, t and the candidate
//               shift amount x; the response side carries the witness
//               verdict, the invertibility condition and the shift count.
// Revision    : 1.0 - initial release
// ============================================================================
interface bvlshr_ne_witness_checker_if #(
   parameter int W = 8
);
   // request channel
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] s;
   logic [W-1:0] t;
   logic [W-1:0] x;

   // response channel
   logic         out_valid;
   logic         out_ready;
   logic         result;
   logic         ic;
   logic [W-1:0] shifts;

   // witness generator / scoreboard side
   modport master (
      output in_valid,
      output s,
      output t,
      output x,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  result,
      input  ic,
      input  shifts
   );

   // checker side
   modport slave (
      input  in_valid,
      input  s,
      input  t,
      input  x,
      input  out_ready,
      output in_ready,
      output out_valid,
      output result,
      output ic,
      output shifts
   );
endinterface

`default_nettype wire

// File: rtl/bvlshr_ne_witness_checker.sv
`default_nettype none
// ============================================================================
// Module      : bvlshr_ne_witness_checker
// Description : Bit-serial checker for bvlshr "not-equal" witnesses. Shifts
//               s right by x one position per cycle (stopping early once the
//               shifted value is zero) and reports whether (s >> x) != t,
//               together with ic = (s != 0) | (t != 0) sampled at accept.
// Revision    : 1.0 - initial release
// ============================================================================
module bvlshr_ne_witness_checker #(
   parameter int W = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   bvlshr_ne_witness_checker_if.slave    bus
);

   localparam logic [W-1:0] c_zero = '0;
   localparam logic [W-1:0] c_one  = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;

   logic [W-1:0] r_sh;        // running shifted copy of s
   logic [W-1:0] r_tq;        // target captured at accept
   logic [W-1:0] r_cnt;       // remaining requested shifts
   logic [W-1:0] r_shifts;    // shifts actually performed
   logic         r_result;
   logic         r_ic;
   logic         r_in_ready;
   logic         r_out_valid;

   logic         w_accept;
   logic         w_stop;
   logic         w_drain;

   // Handshake qualifiers; r_in_ready is only ever high in IDLE.
   assign w_accept = bus.in_valid & r_in_ready;
   assign w_drain  = bus.out_ready & r_out_valid;

   // Once the shifted value is zero further shifts cannot change it, so the
   // walk stops there even if the requested amount is still non-zero. This
   // bounds the SHIFT phase to W+1 cycles regardless of x.
   assign w_stop   = (r_cnt == c_zero) | (r_sh == c_zero);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_stop) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (w_drain) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Handshake flags are registered copies of the next-state decode so that
   // neither ready nor valid has a combinational path from the inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_nxt == ST_IDLE);
         r_out_valid <= (w_state_nxt == ST_DONE);
      end
   end

   // Operand capture, serial shift and result latch. In DONE nothing is
   // written, so result/ic/shifts hold for as long as the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh     <= c_zero;
         r_tq     <= c_zero;
         r_cnt    <= c_zero;
         r_shifts <= c_zero;
         r_result <= 1'b0;
         r_ic     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_sh     <= bus.s;
                  r_tq     <= bus.t;
                  r_cnt    <= bus.x;
                  r_shifts <= c_zero;
                  r_ic     <= (bus.s != c_zero) | (bus.t != c_zero);
               end
            end
            ST_SHIFT: begin
               if (w_stop) begin
                  r_result <= (r_sh != r_tq);
               end else begin
                  // r_cnt is known non-zero here, so the decrement never wraps
                  r_sh     <= r_sh >> 1;
                  r_cnt    <= r_cnt - c_one;
                  r_shifts <= r_shifts + c_one;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output drive.
   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.ic        = r_ic;
   assign bus.shifts    = r_shifts;

endmodule

`default_nettype wire
